// File: rtl/scrolling_pkg.sv
// Shared types, default sizes and the offset-step helper for the scrolling sequencer.
package scrolling_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    WAIT = 2'd2,
    STEP = 2'd3
  } scroll_state_e;

  localparam int unsigned SCROLL_MSG_DEPTH = 16;
  localparam int unsigned SCROLL_CHAR_W    = 8;

  // Circular step: dir=0 increments, dir=1 decrements, both modulo eff_len.
  function automatic int unsigned next_offset(input int unsigned offset,
                                              input int unsigned eff_len,
                                              input logic        dir);
    if (eff_len == 0) begin
      return 0;
    end
    if (!dir) begin
      return (offset == eff_len - 1) ? 0 : offset + 1;
    end
    return (offset == 0) ? eff_len - 1 : offset - 1;
  endfunction

endpackage

// File: rtl/scrolling_ctrl_window.sv
// Registered window extraction: char i = buf[(offset+i) mod eff_len], zero when eff_len is 0.
module scroll_window #(
  parameter int unsigned MSG_DEPTH = 16,
  parameter int unsigned WIN_WIDTH = 4,
  parameter int unsigned CHAR_W    = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [MSG_DEPTH*CHAR_W-1:0]     buf_flat,
  input  logic [$clog2(MSG_DEPTH)-1:0]    offset,
  input  logic [$clog2(MSG_DEPTH):0]      eff_len,
  output logic [WIN_WIDTH*CHAR_W-1:0]     win_chars
);

  logic [WIN_WIDTH*CHAR_W-1:0] win_d, win_q;
  int unsigned                 sum;
  int unsigned                 idx;

  always_comb begin
    win_d = '0;
    sum   = 0;
    idx   = 0;
    if (eff_len != '0) begin
      for (int unsigned i = 0; i < WIN_WIDTH; i++) begin
        sum = int'(offset) + i;
        idx = sum % int'(eff_len);
        win_d[i*CHAR_W +: CHAR_W] = buf_flat[idx*CHAR_W +: CHAR_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q <= '0;
    end else begin
      win_q <= win_d;
    end
  end

  assign win_chars = win_q;

endmodule

// File: rtl/scrolling_ctrl.sv
// Scroll sequencer: message buffer, timer handshake FSM and circular offset.
// Define SCROLL_BOUNCE_EN to reverse direction at the ends instead of wrapping.
module scrolling_ctrl
  import scrolling_pkg::*;
#(
  parameter int unsigned MSG_DEPTH = SCROLL_MSG_DEPTH,
  parameter int unsigned WIN_WIDTH = 4,
  parameter int unsigned CHAR_W    = SCROLL_CHAR_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_we,
  input  logic [$clog2(MSG_DEPTH)-1:0]  cfg_addr,
  input  logic [CHAR_W-1:0]             cfg_wdata,
  input  logic [$clog2(MSG_DEPTH):0]    msg_len,
  input  logic                          scroll_en,
  input  logic                          dir,
  input  logic [31:0]                   period,
  output logic                          cnt_start,
  output logic [31:0]                   cnt_value,
  input  logic                          cnt_done,
  output logic [WIN_WIDTH*CHAR_W-1:0]   win_chars,
  output logic [$clog2(MSG_DEPTH)-1:0]  offset,
  output logic                          wrap_pulse,
  output logic                          busy
);

  localparam int unsigned OW = $clog2(MSG_DEPTH);
  localparam int unsigned LW = OW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(MSG_DEPTH);

  scroll_state_e           state_d, state_q;
  logic                    run_dir_d, run_dir_q;
  logic [OW-1:0]           offset_d, offset_q;
  logic                    wrap_d, wrap_q;
  logic                    cnt_start_d, cnt_start_q;
  logic [31:0]             cnt_value_d, cnt_value_q;
  logic [CHAR_W-1:0]       msg_buf_d [MSG_DEPTH];
  logic [CHAR_W-1:0]       msg_buf_q [MSG_DEPTH];
  logic [MSG_DEPTH*CHAR_W-1:0] buf_flat;
  logic [LW-1:0]           eff_len;
  logic                    at_end;

  assign eff_len = (msg_len > DEPTH_L) ? DEPTH_L : msg_len;
  assign at_end  = run_dir_q ? (offset_q == '0)
                             : ({1'b0, offset_q} == eff_len - 1'b1);

  always_comb begin
    state_d     = state_q;
    run_dir_d   = run_dir_q;
    offset_d    = offset_q;
    wrap_d      = 1'b0;
    cnt_start_d = 1'b0;
    cnt_value_d = cnt_value_q;
    msg_buf_d   = msg_buf_q;
    if (cfg_we) begin
      msg_buf_d[cfg_addr] = cfg_wdata;
    end

    case (state_q)
      IDLE: begin
        if (scroll_en && (eff_len != '0)) begin
          state_d   = ARM;
          run_dir_d = dir;
        end
      end
      ARM: state_d = WAIT;
      WAIT: begin
        if (cnt_done) begin
          state_d = STEP;
        end else if (!scroll_en) begin
          state_d = IDLE;
        end
      end
      STEP: begin
        state_d = scroll_en ? ARM : IDLE;
        wrap_d  = at_end;
`ifdef SCROLL_BOUNCE_EN
        // At an end, step once in the reversed direction so the end char is not repeated.
        if (at_end) begin
          run_dir_d = ~run_dir_q;
          offset_d  = OW'(next_offset(32'(offset_q), 32'(eff_len), ~run_dir_q));
        end else begin
          offset_d  = OW'(next_offset(32'(offset_q), 32'(eff_len), run_dir_q));
        end
`else
        offset_d = OW'(next_offset(32'(offset_q), 32'(eff_len), run_dir_q));
`endif
      end
      default: state_d = IDLE;
    endcase

    // A shrunk message overrides any step this cycle.
    if ({1'b0, offset_q} >= eff_len) begin
      offset_d = '0;
      wrap_d   = 1'b0;
    end

    if (state_d == ARM) begin
      cnt_start_d = 1'b1;
      cnt_value_d = period;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      run_dir_q   <= 1'b0;
      offset_q    <= '0;
      wrap_q      <= 1'b0;
      cnt_start_q <= 1'b0;
      cnt_value_q <= '0;
      msg_buf_q   <= '{default: '0};
    end else begin
      state_q     <= state_d;
      run_dir_q   <= run_dir_d;
      offset_q    <= offset_d;
      wrap_q      <= wrap_d;
      cnt_start_q <= cnt_start_d;
      cnt_value_q <= cnt_value_d;
      msg_buf_q   <= msg_buf_d;
    end
  end

  always_comb begin
    buf_flat = '0;
    for (int unsigned i = 0; i < MSG_DEPTH; i++) begin
      buf_flat[i*CHAR_W +: CHAR_W] = msg_buf_q[i];
    end
  end

  scroll_window #(
    .MSG_DEPTH (MSG_DEPTH),
    .WIN_WIDTH (WIN_WIDTH),
    .CHAR_W    (CHAR_W)
  ) u_window (
    .clk       (clk),
    .rst_n     (rst_n),
    .buf_flat  (buf_flat),
    .offset    (offset_q),
    .eff_len   (eff_len),
    .win_chars (win_chars)
  );

  assign cnt_start  = cnt_start_q;
  assign cnt_value  = cnt_value_q;
  assign offset     = offset_q;
  assign wrap_pulse = wrap_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_scrolling_ctrl.sv
// Directed self-checking bench for scrolling_ctrl (circular and SCROLL_BOUNCE_EN builds).
module tb_scrolling_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [7:0]  cfg_wdata;
  logic [4:0]  msg_len;
  logic        scroll_en;
  logic        dir;
  logic [31:0] period;
  logic        cnt_start;
  logic [31:0] cnt_value;
  logic        cnt_done;
  logic [31:0] win_chars;
  logic [3:0]  offset;
  logic        wrap_pulse;
  logic        busy;

  int unsigned checks = 0;
  int unsigned errors = 0;

  scrolling_ctrl #(
    .MSG_DEPTH (16),
    .WIN_WIDTH (4),
    .CHAR_W    (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .msg_len    (msg_len),
    .scroll_en  (scroll_en),
    .dir        (dir),
    .period     (period),
    .cnt_start  (cnt_start),
    .cnt_value  (cnt_value),
    .cnt_done   (cnt_done),
    .win_chars  (win_chars),
    .offset     (offset),
    .wrap_pulse (wrap_pulse),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] win_of(input string s);
    return {s[3], s[2], s[1], s[0]};
  endfunction

  task automatic load_msg();
    string m = "ABCDEFGH";
    for (int i = 0; i < 8; i++) begin
      cfg_we    = 1'b1;
      cfg_addr  = 4'(i);
      cfg_wdata = m[i];
      tick();
    end
    cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Expects to be in ARM (or about to be); runs one timer period and one STEP.
  task automatic step_once(input string win_before, input int unsigned exp_off, input logic exp_wrap);
    int unsigned n = 0;
    while (cnt_start !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("cnt_start", {31'd0, cnt_start}, 32'd1);
    chk("cnt_value", cnt_value, 32'd3);
    tick();
    chk("start_pulse_len", {31'd0, cnt_start}, 32'd0);
    chk("win", win_chars, win_of(win_before));
    repeat (2) tick();
    cnt_done = 1'b1;
    tick();
    cnt_done = 1'b0;
    tick();
    chk("offset", {28'd0, offset}, exp_off);
    chk("wrap", {31'd0, wrap_pulse}, {31'd0, exp_wrap});
  endtask

  initial begin
    rst_n     = 1'b0;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_wdata = '0;
    msg_len   = 5'd8;
    scroll_en = 1'b0;
    dir       = 1'b0;
    period    = 32'd3;
    cnt_done  = 1'b0;
    tick();
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_offset", {28'd0, offset}, 32'd0);
    chk("rst_win", win_chars, 32'd0);
    chk("rst_cnt_start", {31'd0, cnt_start}, 32'd0);
    chk("rst_cnt_value", cnt_value, 32'd0);
    chk("rst_wrap", {31'd0, wrap_pulse}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Left scroll over "ABCDEFGH"
    load_msg();
    scroll_en = 1'b1;
    tick();
    chk("busy_run", {31'd0, busy}, 32'd1);
    step_once("ABCD", 1, 1'b0);
    step_once("BCDE", 2, 1'b0);
    step_once("CDEF", 3, 1'b0);
    step_once("DEFG", 4, 1'b0);
    step_once("EFGH", 5, 1'b0);
    step_once("FGHA", 6, 1'b0);
    step_once("GHAB", 7, 1'b0);
`ifdef SCROLL_BOUNCE_EN
    step_once("HABC", 6, 1'b1);
`else
    step_once("HABC", 0, 1'b1);
`endif
    scroll_en = 1'b0;
    repeat (3) tick();
    chk("stop_busy", {31'd0, busy}, 32'd0);

    // Right scroll, msg_len=5; dir change after start must be ignored
    do_reset();
    load_msg();
    msg_len   = 5'd5;
    dir       = 1'b1;
    scroll_en = 1'b1;
    tick();
    dir = 1'b0;
`ifdef SCROLL_BOUNCE_EN
    step_once("ABCD", 1, 1'b1);
    step_once("BCDE", 2, 1'b0);
`else
    step_once("ABCD", 4, 1'b1);
    step_once("EABC", 3, 1'b0);
`endif
    scroll_en = 1'b0;
    repeat (3) tick();

    // cnt_done coincident with scroll_en falling
    do_reset();
    load_msg();
    msg_len   = 5'd8;
    dir       = 1'b0;
    scroll_en = 1'b1;
    tick();
    tick();
    cnt_done  = 1'b1;
    scroll_en = 1'b0;
    tick();
    cnt_done = 1'b0;
    chk("coinc_step_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("coinc_offset", {28'd0, offset}, 32'd1);
    chk("coinc_idle", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("coinc_no_start", {31'd0, cnt_start}, 32'd0);
      tick();
    end
    cnt_done = 1'b1;
    tick();
    cnt_done = 1'b0;
    tick();
    chk("spurious_offset", {28'd0, offset}, 32'd1);
    chk("spurious_busy", {31'd0, busy}, 32'd0);
    chk("spurious_win", win_chars, win_of("BCDE"));

    // Shrink 8 -> 3 while offset=6
    scroll_en = 1'b1;
    tick();
    step_once("BCDE", 2, 1'b0);
    step_once("CDEF", 3, 1'b0);
    step_once("DEFG", 4, 1'b0);
    step_once("EFGH", 5, 1'b0);
    step_once("FGHA", 6, 1'b0);
    scroll_en = 1'b0;
    msg_len   = 5'd3;
    tick();
    chk("shrink_offset", {28'd0, offset}, 32'd0);
    chk("shrink_wrap", {31'd0, wrap_pulse}, 32'd0);
    tick();
    chk("shrink_win", win_chars, win_of("ABCA"));
    chk("shrink_idle", {31'd0, busy}, 32'd0);

    // msg_len=0 never starts
    msg_len   = 5'd0;
    scroll_en = 1'b1;
    repeat (3) tick();
    chk("len0_busy", {31'd0, busy}, 32'd0);
    chk("len0_start", {31'd0, cnt_start}, 32'd0);
    chk("len0_win", win_chars, 32'd0);

    // Clamp: msg_len above depth behaves as 16
    scroll_en = 1'b0;
    msg_len   = 5'd20;
    tick();
    tick();
    chk("clamp_win", win_chars, win_of("ABCD"));

    // Asynchronous reset mid-WAIT
    msg_len   = 5'd8;
    scroll_en = 1'b1;
    tick();
    step_once("ABCD", 1, 1'b0);
    tick();
    chk("prewait_busy", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_offset", {28'd0, offset}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_win", win_chars, 32'd0);
    chk("arst_cnt_start", {31'd0, cnt_start}, 32'd0);
    chk("arst_cnt_value", cnt_value, 32'd0);
    chk("arst_wrap", {31'd0, wrap_pulse}, 32'd0);
    scroll_en = 1'b0;
    cnt_done  = 1'b1;
    #2;
    rst_n = 1'b1;
    tick();
    cnt_done = 1'b0;
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_offset", {28'd0, offset}, 32'd0);
    tick();
    chk("post_rst_buf_clear", win_chars, 32'd0);

    // msg_len=4: bounce reverses at both ends, circular wraps at 3
    load_msg();
    msg_len   = 5'd4;
    dir       = 1'b0;
    scroll_en = 1'b1;
    tick();
    step_once("ABCD", 1, 1'b0);
    step_once("BCDA", 2, 1'b0);
    step_once("CDAB", 3, 1'b0);
`ifdef SCROLL_BOUNCE_EN
    step_once("DABC", 2, 1'b1);
    step_once("CDAB", 1, 1'b0);
    step_once("BCDA", 0, 1'b0);
    step_once("ABCD", 1, 1'b1);
`else
    step_once("DABC", 0, 1'b1);
    step_once("ABCD", 1, 1'b0);
`endif
    scroll_en = 1'b0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
